// File: rtl/input_buffer_pkg.sv
// Shared defaults and pointer/count types for the input_buffer staging FIFO.
package input_buffer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 24;
  localparam int unsigned DEF_ADDR_WIDTH = 2;
  localparam int unsigned DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

  typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;
  typedef logic [DEF_ADDR_WIDTH:0]   cnt_t;

endpackage : input_buffer_pkg

// File: rtl/input_buffer_ram.sv
// DEPTH x DATA_WIDTH storage with one write port, a registered read port
// and a synchronous clear; the read register can also be loaded directly.
module input_buffer_ram
  import input_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic                  i_byp,
  input  logic [DATA_WIDTH-1:0] i_byp_data,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (i_we) begin
        mem_q[i_waddr] <= i_wdata;
      end
      // A bypass load takes priority; it only occurs when nothing is stored.
      if (i_byp) begin
        rdata_q <= i_byp_data;
      end else if (i_re) begin
        rdata_q <= mem_q[i_raddr];
      end
    end
  end

  assign o_rdata = rdata_q;

endmodule : input_buffer_ram

// File: rtl/input_buffer.sv
// Synchronous staging FIFO ahead of the systolic array feeder.
// Define INPUT_BUFFER_BYPASS_EN for empty-buffer first-word fall-through.
module input_buffer
  import input_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  rd_acc, wr_acc, byp;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_W'(DEPTH));

`ifdef INPUT_BUFFER_BYPASS_EN
  assign byp = o_empty & i_rd & i_wr;
`else
  assign byp = 1'b0;
`endif

  // A bypassed word never touches storage, so it is not an accepted write.
  assign rd_acc = i_rd & ~o_empty;
  assign wr_acc = i_wr & (~o_full | rd_acc) & ~byp;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_count = count_q;

  input_buffer_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (wr_acc),
    .i_waddr    (wr_ptr_q),
    .i_wdata    (i_wr_data),
    .i_re       (rd_acc),
    .i_raddr    (rd_ptr_q),
    .i_byp      (byp),
    .i_byp_data (i_wr_data),
    .o_rdata    (o_data)
  );

endmodule : input_buffer

// File: tb/tb_input_buffer.sv
// Directed plus random stimulus against a queue-based reference of the FIFO.
module tb_input_buffer;
  import input_buffer_pkg::*;

  localparam int unsigned DW    = DEF_DATA_WIDTH;
  localparam int unsigned DEPTH = DEF_DEPTH;

  logic          clk = 1'b0;
  logic          rst, rd, wr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] o_data;
  cnt_t          o_count;
  logic          o_empty, o_full;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_data;

  always #5 clk = ~clk;

  input_buffer dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rd      (rd),
    .i_wr      (wr),
    .i_wr_data (wr_data),
    .o_data    (o_data),
    .o_count   (o_count),
    .o_empty   (o_empty),
    .o_full    (o_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: the buffer is an ordered list of at most DEPTH words.
  task automatic model_update(input logic r, input logic rq, input logic wq, input logic [DW-1:0] d);
    bit was_empty, was_full, rd_ok, wr_ok;
    if (r) begin
      model_q.delete();
      exp_data = '0;
      return;
    end
    was_empty = (model_q.size() == 0);
    was_full  = (model_q.size() == DEPTH);
`ifdef INPUT_BUFFER_BYPASS_EN
    if (was_empty && rq && wq) begin
      exp_data = d;
      return;
    end
`endif
    rd_ok = rq && !was_empty;
    wr_ok = wq && (!was_full || rd_ok);
    if (rd_ok) exp_data = model_q.pop_front();
    if (wr_ok) model_q.push_back(d);
  endtask

  task automatic step(input string tag, input logic r, input logic rq, input logic wq, input logic [DW-1:0] d);
    rst = r; rd = rq; wr = wq; wr_data = d;
    @(posedge clk);
    #1;
    model_update(r, rq, wq, d);
    chk({tag, ".data"},  32'(o_data),  32'(exp_data));
    chk({tag, ".count"}, 32'(o_count), model_q.size());
    chk({tag, ".empty"}, 32'(o_empty), 32'(model_q.size() == 0));
    chk({tag, ".full"},  32'(o_full),  32'(model_q.size() == DEPTH));
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] v;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; wr_data = '0;
    exp_data = '0;
    @(negedge clk);

    // Basic ordering and occupancy
    step("rst1", 1, 0, 0, '0);
    chk("rst1_empty", 32'(o_empty), 32'd1);
    step("w1", 0, 0, 1, 24'h111111);
    step("w2", 0, 0, 1, 24'h222222);
    step("w3", 0, 0, 1, 24'h333333);
    chk("cnt3", 32'(o_count), 32'd3);
    step("r1", 0, 1, 0, '0); chk("r1_val", 32'(o_data), 32'h111111);
    step("r2", 0, 1, 0, '0); chk("r2_val", 32'(o_data), 32'h222222);
    step("r3", 0, 1, 0, '0); chk("r3_val", 32'(o_data), 32'h333333);
    chk("r3_empty", 32'(o_empty), 32'd1);

    // Reads while empty hold o_data
    for (int i = 0; i < 3; i++) step("rd_empty", 0, 1, 0, '0);
    chk("hold_val", 32'(o_data), 32'h333333);
    chk("hold_cnt", 32'(o_count), 32'd0);

    // Multi-cycle reset clears o_data; reads stay at zero
    for (int i = 0; i < 5; i++) step("rst5", 1, 1, 1, 24'hFFFFFF);
    for (int i = 0; i < 5; i++) step("rd_after_rst", 0, 1, 0, '0);
    chk("rst_zero", 32'(o_data), 32'h0);

    // Overfill: fifth word dropped
    for (int i = 0; i < 5; i++) begin
      step("fill", 0, 0, 1, DW'(32'hA0 + 32'(i)));
      if (i == 3) chk("full_after4", 32'(o_full), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step("drain", 0, 1, 0, '0);
      chk("drain_val", 32'(o_data), 32'hA0 + 32'(i));
    end
    chk("drain_empty", 32'(o_empty), 32'd1);

    // Simultaneous rd/wr when full
    for (int i = 0; i < 4; i++) step("refill", 0, 0, 1, DW'(32'hD0 + 32'(i)));
    step("full_rw", 0, 1, 1, 24'h0000BB);
    chk("full_rw_cnt", 32'(o_count), 32'd4);
    chk("full_rw_val", 32'(o_data), 32'hD0);
    for (int i = 1; i < 4; i++) begin
      step("pop", 0, 1, 0, '0);
      chk("pop_val", 32'(o_data), 32'hD0 + 32'(i));
    end
    step("pop_bb", 0, 1, 0, '0);
    chk("bb_val", 32'(o_data), 32'hBB);

    // Simultaneous rd/wr when empty
    step("empty_rw", 0, 1, 1, 24'h0000CC);
`ifdef INPUT_BUFFER_BYPASS_EN
    chk("byp_val", 32'(o_data), 32'hCC);
    chk("byp_cnt", 32'(o_count), 32'd0);
`else
    chk("nobyp_val", 32'(o_data), 32'hBB);
    chk("nobyp_cnt", 32'(o_count), 32'd1);
`endif

    // Random traffic, many pointer wraps, occasional reset
    for (int i = 0; i < 600; i++) begin
      v = DW'($urandom);
      step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 55), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_input_buffer

// File: doc/input_buffer.md
Name: input_buffer

Overview:
- Synchronous FIFO staging operand words (e.g. 3 packed 8-bit activations = 24 bits) in front of the systolic array feeder.
- Depth 2**ADDR_WIDTH entries; single clock domain.
- Registered read data; status flags for the upstream writer and downstream reader.

Parameters:
- DATA_WIDTH, 24, width of each stored word and of i_wr_data/o_data.
- ADDR_WIDTH, 2, pointer width; depth DEPTH = 2**ADDR_WIDTH (4 by default).

Ports:
- i_clk  input  1  single clock; all logic on rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_rd  input  1  read request (pop).
- i_wr  input  1  write request (push).
- i_wr_data  input  DATA_WIDTH  word to push when i_wr=1.
- o_data  output  DATA_WIDTH  registered popped word.
- o_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- o_empty  output  1  o_count==0 (combinational from count register).
- o_full  output  1  o_count==DEPTH.
- Port order as listed; i_clk..o_data are positionally fixed.

Behaviour:
- Reset: sampled on rising edge with i_rst=1. Clears wr_ptr, rd_ptr, count, o_data to 0 and all memory entries to 0. Holding reset for N cycles is equivalent to 1 cycle. Reset overrides any simultaneous rd/wr; flags are o_empty=1, o_full=0 from the first edge after reset.
- Accepted write: wr_acc = i_wr & (~o_full | rd_acc). Stores mem[wr_ptr] <= i_wr_data, then wr_ptr+1, wrapping modulo DEPTH.
- Accepted read: rd_acc = i_rd & ~o_empty. o_data <= mem[rd_ptr], then rd_ptr+1, wrapping modulo DEPTH.
- Read latency: one cycle. Data appears on o_data after the rising edge that accepts i_rd, so a value sampled at that same edge is the previous o_data.
- Read when empty: ignored; pointers unchanged; o_data holds its last value.
- Write when full without an accepted read: ignored; no overwrite.
- Simultaneous rd & wr:
  - Not empty: both occur, count unchanged.
  - Full: both occur (write uses the freed slot).
  - Empty: write only; o_data holds (no bypass unless the optional feature is enabled).
- Count update: count += wr_acc - rd_acc. Never exceeds DEPTH, never underflows.
- Pointers are ADDR_WIDTH bits; wrap from DEPTH-1 to 0 is seamless across any number of passes.

Optional Feature:
- Macro INPUT_BUFFER_BYPASS_EN.
- Defined: when o_empty=1 and i_rd=1 and i_wr=1 in the same cycle, o_data <= i_wr_data directly and the word is not stored. Pointers and count are unchanged, giving zero-storage first-word fall-through.
- Undefined: baseline behaviour; only the write occurs.

Decomposition:
- Package input_buffer_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH localparams
  - typedef for pointer (logic [ADDR_WIDTH-1:0])
  - typedef for count (logic [ADDR_WIDTH:0])
- One natural sub-module: input_buffer_ram.
  - Ports: DEPTH x DATA_WIDTH array, write port, registered read port, synchronous clear on i_rst.
- Pointer/count/flag control stays in input_buffer.

Test Plan:
- Reset 1 cycle, write 0x111111, 0x222222, 0x333333, then 3 reads -> o_data after each read edge = 0x111111, 0x222222, 0x333333; o_count 3->0; o_empty=1 at end.
- Then 3 more reads while empty -> o_data stays 0x333333; o_count stays 0; pointers unchanged.
- Hold i_rst for 5 cycles, then 5 reads -> o_data = 0x000000 throughout; o_empty=1.
- Write 5 words 0xA0..0xA4 -> o_full=1 after 4; 0xA4 dropped. Read 4 -> 0xA0..0xA3.
- Full buffer with i_rd=i_wr=1 and data 0xBB -> o_count stays 4; 0xBB emerges after the next 3 pops.
- Empty with rd&wr and data 0xCC:
  - Baseline: o_data unchanged, o_count=1.
  - With INPUT_BUFFER_BYPASS_EN: o_data=0xCC next cycle, o_count=0.
